icache_line_fill: RTL and testbench

ICACHE_LINE_FILL -- requirements
Module: icache_line_fill

---
 rtl/icache_line_fill_if.sv | 24 ++
 rtl/icache_line_fill.sv | 148 ++++++++++++++
 tb/tb_icache_line_fill.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_line_fill_if.sv
// Wishbone B4 read-burst bus between the instruction-cache line filler and memory.
// The master drives cycle/strobe/address/burst tags; the slave returns data, ack and error.
interface icache_line_fill_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_cti_o, wb_bte_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_cti_o, wb_bte_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/icache_line_fill.sv
// Fetches one 32-byte instruction-cache line as an 8-beat Wishbone linear burst,
// aborting on bus error, per-beat ack timeout or flush.
module icache_line_fill #(
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fill_req,
  input  logic [31:0]          fill_addr,
  input  logic                 flush,
  output logic                 fill_busy,
  output logic                 fill_done,
  output logic                 fill_err,
  output logic [255:0]         line_data,
  icache_line_fill_if.master   wb
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Abort fires when this many consecutive strobe cycles have already gone unanswered.
  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t        state_r, state_s;
  logic [26:0]   line_addr_r, line_addr_s;
  logic [2:0]    beat_r, beat_s;
  logic [7:0]    timer_r, timer_s;
  logic          capture_s;
  logic          err_s;
  logic          cyc_s;
  logic          cyc_r;
  logic [31:0]   adr_s, adr_r;
  logic [3:0]    sel_s, sel_r;
  logic [2:0]    cti_s, cti_r;
  logic          busy_r, done_r, err_r;
  logic [255:0]  line_data_r;

  // Next-state, beat bookkeeping and abort decisions.
  always_comb begin
    state_s     = state_r;
    line_addr_s = line_addr_r;
    beat_s      = beat_r;
    timer_s     = timer_r;
    capture_s   = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fill_req && !flush) begin
          state_s     = ST_BURST;
          line_addr_s = fill_addr[31:5];
          beat_s      = 3'd0;
          timer_s     = 8'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (flush) begin
          state_s = ST_IDLE;
        end else if (wb.wb_err_i || (!wb.wb_ack_i && (timer_r == TIMEOUT_LAST))) begin
          state_s = ST_IDLE;
          err_s   = 1'b1;
        end else if (wb.wb_ack_i) begin
          capture_s = 1'b1;
          timer_s   = 8'd0;
          if (beat_r == 3'd7) begin
            state_s = ST_DONE;
          end else begin
            beat_s = beat_r + 3'd1;
          end
        end else begin
          timer_s = timer_r + 8'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Bus outputs are decoded from the next state so they leave the flops cleanly.
  always_comb begin
    cyc_s = (state_s == ST_BURST);
    if (cyc_s) begin
      adr_s = {line_addr_s, beat_s, 2'b00};
      sel_s = 4'hF;
      cti_s = (beat_s == 3'd7) ? 3'b111 : 3'b010;
    end else begin
      adr_s = 32'h0000_0000;
      sel_s = 4'h0;
      cti_s = 3'b000;
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      line_addr_r <= 27'd0;
      beat_r      <= 3'd0;
      timer_r     <= 8'd0;
      cyc_r       <= 1'b0;
      adr_r       <= 32'h0000_0000;
      sel_r       <= 4'h0;
      cti_r       <= 3'b000;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      line_data_r <= 256'd0;
    end else begin
      state_r     <= state_s;
      line_addr_r <= line_addr_s;
      beat_r      <= beat_s;
      timer_r     <= timer_s;
      cyc_r       <= cyc_s;
      adr_r       <= adr_s;
      sel_r       <= sel_s;
      cti_r       <= cti_s;
      busy_r      <= (state_s != ST_IDLE);
      done_r      <= (state_s == ST_DONE);
      err_r       <= err_s;
      if (capture_s) begin
        line_data_r[32 * beat_r +: 32] <= wb.wb_dat_i;
      end else begin
        line_data_r <= line_data_r;
      end
    end
  end

  assign fill_busy   = busy_r;
  assign fill_done   = done_r;
  assign fill_err    = err_r;
  assign line_data   = line_data_r;
  assign wb.wb_cyc_o = cyc_r;
  assign wb.wb_stb_o = cyc_r;
  assign wb.wb_we_o  = 1'b0;
  assign wb.wb_adr_o = adr_r;
  assign wb.wb_sel_o = sel_r;
  assign wb.wb_cti_o = cti_r;
  assign wb.wb_bte_o = 2'b00;

endmodule

// File: tb/tb_icache_line_fill.sv
// Directed bench for icache_line_fill: scripted Wishbone slave, cycle model checked every cycle,
// plus hand-computed expectations for latency, addresses and line contents.
module tb_icache_line_fill;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fill_req = 1'b0;
  logic [31:0]  fill_addr = 32'h0;
  logic         flush = 1'b0;
  logic         fill_busy, fill_done, fill_err;
  logic [255:0] line_data;

  icache_line_fill_if bus ();

  icache_line_fill #(.ACK_TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fill_req  (fill_req),
    .fill_addr (fill_addr),
    .flush     (flush),
    .fill_busy (fill_busy),
    .fill_done (fill_done),
    .fill_err  (fill_err),
    .line_data (line_data),
    .wb        (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Scripted slave: data = data_base + beat index, optional wait states / error / silence.
  int          wait_beat = -1;
  int          wait_n = 0;
  int          err_beat = -1;
  bit          never_ack = 1'b0;
  logic [31:0] data_base = 32'hA0;
  int          wcnt = 0;
  int          sb;

  initial begin
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_dat_i = 32'h0;
    forever begin
      @(negedge clk);
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
      bus.wb_dat_i = 32'h0;
      if (bus.wb_cyc_o && bus.wb_stb_o) begin
        sb = int'(bus.wb_adr_o[4:2]);
        bus.wb_dat_i = data_base + 32'(sb);
        if (never_ack) begin
          bus.wb_ack_i = 1'b0;
        end else if (sb == err_beat) begin
          bus.wb_err_i = 1'b1;
          bus.wb_ack_i = 1'b1;
        end else if (sb == wait_beat && wcnt < wait_n) begin
          wcnt++;
        end else begin
          bus.wb_ack_i = 1'b1;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Behavioural model: a fill is "in flight" on a line base, walking beats 0..7.
  logic        m_active, m_done, m_err;
  logic [26:0] m_base;
  int          m_beat, m_wait;
  logic [31:0] m_line [8];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      m_base <= 27'd0; m_beat <= 0; m_wait <= 0;
      for (int i = 0; i < 8; i++) m_line[i] <= 32'h0;
    end else begin
      m_err <= 1'b0;
      if (m_done) begin
        m_done <= 1'b0;
      end else if (m_active) begin
        if (flush) begin
          m_active <= 1'b0;
        end else if (bus.wb_err_i || (!bus.wb_ack_i && (m_wait + 1 == TO))) begin
          m_active <= 1'b0;
          m_err    <= 1'b1;
        end else if (bus.wb_ack_i) begin
          m_line[m_beat] <= bus.wb_dat_i;
          m_wait <= 0;
          if (m_beat == 7) begin
            m_active <= 1'b0;
            m_done   <= 1'b1;
          end else begin
            m_beat <= m_beat + 1;
          end
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if (fill_req && !flush) begin
        m_active <= 1'b1;
        m_base   <= fill_addr[31:5];
        m_beat   <= 0;
        m_wait   <= 0;
      end
    end
  end

  logic [46:0]  got_v, exp_v;
  logic [255:0] exp_line;

  // Every cycle out of reset, all outputs must match the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        got_v = {fill_busy, fill_done, fill_err, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o,
                 bus.wb_sel_o, bus.wb_cti_o, bus.wb_bte_o, bus.wb_adr_o};
        exp_v = {m_active | m_done, m_done, m_err, m_active, m_active, 1'b0,
                 m_active ? 4'hF : 4'h0,
                 m_active ? ((m_beat == 7) ? 3'b111 : 3'b010) : 3'b000,
                 2'b00,
                 m_active ? {m_base, 3'(m_beat), 2'b00} : 32'h0};
        exp_line = {m_line[7], m_line[6], m_line[5], m_line[4],
                    m_line[3], m_line[2], m_line[1], m_line[0]};
        chk("model_outputs", 256'(got_v), 256'(exp_v));
        chk("model_line", line_data, exp_line);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // Request lasts one cycle T; returns at the sampling point of cycle T+1.
  task automatic request(input logic [31:0] a);
    @(negedge clk);
    fill_addr = a;
    fill_req  = 1'b1;
    @(negedge clk);
    fill_req  = 1'b0;
  endtask

  logic [255:0] line_a, line_c, line_b;

  initial begin
    line_a = {32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0};
    line_c = {32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hC1, 32'hC0};
    line_b = {32'hB7, 32'hB6, 32'hB5, 32'hB4, 32'hB3, 32'hB2, 32'hB1, 32'hB0};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {fill_busy, fill_done, fill_err, bus.wb_cyc_o, bus.wb_adr_o}, 256'd0);
    chk("reset_line", line_data, 256'd0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait fill of 0x1234.
    data_base = 32'hA0;
    request(32'h0000_1234);
    for (int k = 0; k < 8; k++) begin
      chk("a_adr", bus.wb_adr_o, 256'(32'h1220 + 32'(4 * k)));
      chk("a_cti", bus.wb_cti_o, (k == 7) ? 256'h7 : 256'h2);
      @(negedge clk);
    end
    chk("a_done_t9", fill_done, 256'd1);
    chk("a_word0", line_data[31:0], 256'hA0);
    chk("a_word7", line_data[255:224], 256'hA7);
    @(negedge clk);
    chk("a_idle_busy", {fill_busy, bus.wb_cyc_o}, 256'd0);

    // Three wait states on beat 4; a second request held during the burst is ignored.
    wait_beat = 4; wait_n = 3;
    request(32'h0000_1234);
    fill_addr = 32'h0000_5000;
    fill_req  = 1'b1;
    for (int n = 1; n < 12; n++) begin
      if (n >= 5 && n <= 8) chk("b_adr_hold", bus.wb_adr_o, 256'h1230);
      if (n == 6) fill_req = 1'b0;
      @(negedge clk);
    end
    chk("b_done_t12", fill_done, 256'd1);
    chk("b_line", line_data, line_a);
    @(negedge clk);
    wait_beat = -1;

    // Error with ack on beat 2.
    data_base = 32'hC0; err_beat = 2;
    request(32'h0000_1234);
    repeat (3) @(negedge clk);
    chk("c_err_pulse", {fill_err, fill_done, fill_busy, bus.wb_cyc_o}, 256'b1000);
    chk("c_line", line_data, line_c);
    err_beat = -1;
    @(negedge clk);
    chk("c_err_one_cycle", fill_err, 256'd0);

    // Silent slave on beat 0 -> timeout abort.
    never_ack = 1'b1;
    request(32'h0000_4000);
    repeat (3) @(negedge clk);
    chk("d_no_err_yet", fill_err, 256'd0);
    @(negedge clk);
    chk("d_timeout_err", {fill_err, bus.wb_cyc_o, bus.wb_stb_o}, 256'b100);
    chk("d_line", line_data, line_c);
    never_ack = 1'b0;
    @(negedge clk);

    // Flush on beat 5, then a fresh fill at 0x2000.
    data_base = 32'hD0;
    request(32'h0000_3000);
    repeat (5) @(negedge clk);
    chk("e_beat5_adr", bus.wb_adr_o, 256'h3014);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("e_flush_quiet", {fill_done, fill_err, fill_busy, bus.wb_cyc_o}, 256'd0);
    data_base = 32'hB0;
    request(32'h0000_2000);
    chk("e_first_adr", bus.wb_adr_o, 256'h2000);
    repeat (8) @(negedge clk);
    chk("e_done", fill_done, 256'd1);
    chk("e_line", line_data, line_b);
    @(negedge clk);

    // Asynchronous reset during beat 3.
    data_base = 32'hE0;
    request(32'h0000_1234);
    repeat (3) @(negedge clk);
    chk("f_beat3_adr", bus.wb_adr_o, 256'h122C);
    #2 rst_n = 1'b0;
    #1;
    chk("f_async_bus", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_adr_o, bus.wb_cti_o}, 256'd0);
    chk("f_async_fill", {fill_busy, fill_done, fill_err}, 256'd0);
    chk("f_async_line", line_data, 256'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("f_stay_idle", {fill_busy, fill_done, fill_err, bus.wb_cyc_o}, 256'd0);
    data_base = 32'hA0;
    request(32'h0000_1234);
    repeat (8) @(negedge clk);
    chk("f_refill_done", fill_done, 256'd1);
    chk("f_refill_line", line_data, line_a);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
